block_decompressor: RTL and testbench

//  Inverse of the 256-bit block compressor. Takes a 16-bit per-block tag plus a stream of 32-bit

---
 rtl/block_decompressor.sv | 184 ++++++++++++++++++
 tb/tb_block_decompressor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/block_decompressor.sv
// Rebuilds one WORDS x WORD_W block per 2*WORDS-bit tag from a stream of payload beats.
// Optional DECOMP_STATS_EN adds block and payload-beat counters.
module block_decompressor #(
    parameter int WORDS  = 8,
    parameter int WORD_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wrtEn,
    input  logic [2*WORDS-1:0]        tag_in,
    input  logic                      tag_valid,
    output logic                      tag_ready,
    input  logic [WORD_W-1:0]         data_in,
    input  logic                      data_valid,
    output logic                      data_ready,
    output logic [WORD_W*WORDS-1:0]   data_out,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef DECOMP_STATS_EN
    ,
    output logic [15:0]               blk_count,
    output logic [15:0]               lit_count
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_OUT    = 2'd2;

    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_REP  = 2'b01;
    localparam logic [1:0] CODE_LIT  = 2'b10;
    localparam logic [1:0] CODE_HALF = 2'b11;

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    // Rebuild one word from its 2-bit code, the previous word and the current beat.
    function automatic logic [WORD_W-1:0] decode_word(
        input logic [1:0]        code,
        input logic [WORD_W-1:0] prev,
        input logic [WORD_W-1:0] beat
    );
        logic [WORD_W-1:0] res;
        case (code)
            CODE_ZERO: res = '0;
            CODE_REP:  res = prev;
            CODE_LIT:  res = beat;
            CODE_HALF: res = {{(WORD_W-16){beat[15]}}, beat[15:0]};
            default:   res = '0;
        endcase
        return res;
    endfunction

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WORD_W-1:0]       prev_q, prev_d;
    logic [2*WORDS-1:0]      tag_q, tag_d;
    logic [WORD_W*WORDS-1:0] data_out_q, data_out_d;
    logic                    out_valid_q, out_valid_d;

    logic [1:0]              code_s;
    logic [WORD_W-1:0]       word_s;
    logic                    tag_hs_s;
    logic                    beat_hs_s;
    logic                    out_hs_s;
    logic                    word_done_s;

    assign code_s      = tag_q[{idx_q, 1'b0} +: 2];
    assign word_s      = decode_word(code_s, prev_q, data_in);
    assign tag_ready   = wrtEn & ~reset & (state_q == ST_IDLE);
    assign data_ready  = wrtEn & ~reset & (state_q == ST_DECODE) & code_s[1];
    assign tag_hs_s    = tag_valid & tag_ready;
    assign beat_hs_s   = data_valid & data_ready;
    assign out_hs_s    = wrtEn & out_valid_q & out_ready & (state_q == ST_OUT);
    // Zero/repeat words need no beat; payload words wait for the handshake.
    assign word_done_s = wrtEn & (state_q == ST_DECODE) & (~code_s[1] | beat_hs_s);

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

    // Next-state logic for the IDLE/DECODE/OUT sequencer and the block datapath.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        prev_d      = prev_q;
        tag_d       = tag_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (tag_hs_s) begin
                    tag_d   = tag_in;
                    idx_d   = '0;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (word_done_s) begin
                    data_out_d[idx_q*WORD_W +: WORD_W] = word_s;
                    prev_d = word_s;
                    if (idx_q == IDX_LAST) begin
                        idx_d       = '0;
                        state_d     = ST_OUT;
                        out_valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_OUT: begin
                if (out_hs_s) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any partial block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            prev_q      <= '0;
            tag_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            prev_q      <= prev_d;
            tag_q       <= tag_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef DECOMP_STATS_EN
    logic [15:0] blk_count_q, blk_count_d;
    logic [15:0] lit_count_q, lit_count_d;

    // Counter increments follow the handshakes, so they freeze with wrtEn.
    always_comb begin
        blk_count_d = blk_count_q;
        lit_count_d = lit_count_q;
        if (out_hs_s) begin
            blk_count_d = blk_count_q + 16'd1;
        end else begin
            blk_count_d = blk_count_q;
        end
        if (beat_hs_s) begin
            lit_count_d = lit_count_q + 16'd1;
        end else begin
            lit_count_d = lit_count_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_count_q <= 16'd0;
            lit_count_q <= 16'd0;
        end else begin
            blk_count_q <= blk_count_d;
            lit_count_q <= lit_count_d;
        end
    end

    assign blk_count = blk_count_q;
    assign lit_count = lit_count_q;
`endif

endmodule

// File: tb/tb_block_decompressor.sv
// Randomized bench for block_decompressor against a transaction-level block model.
module tb_block_decompressor;

    logic         clk = 1'b0;
    logic         reset;
    logic         wrtEn;
    logic [15:0]  tag_in;
    logic         tag_valid;
    logic         tag_ready;
    logic [31:0]  data_in;
    logic         data_valid;
    logic         data_ready;
    logic [255:0] data_out;
    logic         out_valid;
    logic         out_ready;
`ifdef DECOMP_STATS_EN
    logic [15:0]  blk_count;
    logic [15:0]  lit_count;
`endif

    always #5 clk = ~clk;

    block_decompressor dut (
        .clk        (clk),
        .reset      (reset),
        .wrtEn      (wrtEn),
        .tag_in     (tag_in),
        .tag_valid  (tag_valid),
        .tag_ready  (tag_ready),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef DECOMP_STATS_EN
        ,
        .blk_count  (blk_count),
        .lit_count  (lit_count)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] prev_m;
    logic [31:0] beats[$];
    int          blk_exp;
    int          lit_exp;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected block from the tag rules alone; beats are taken in order.
    function automatic void model_block(input logic [15:0] tag, output logic [255:0] exp, output int nb);
        logic [31:0] val;
        logic [31:0] b;
        int k = 0;
        exp = '0;
        for (int w = 0; w < 8; w++) begin
            case (tag[2*w +: 2])
                2'b00: val = 32'h0;
                2'b01: val = prev_m;
                2'b10: begin val = beats[k]; k++; end
                default: begin b = beats[k]; val = {{16{b[15]}}, b[15:0]}; k++; end
            endcase
            exp[32*w +: 32] = val;
            prev_m = val;
        end
        nb = k;
    endfunction

    task automatic tag_handshake(input logic [15:0] tag);
        bit hs = 1'b0;
        int waitc = 0;
        wrtEn = 1'b1; tag_in = tag; tag_valid = 1'b1; data_valid = 1'b0; out_ready = 1'b0;
        while (!hs && waitc < 20) begin
            @(negedge clk);
            hs = tag_ready;
            @(posedge clk); #1;
            waitc++;
        end
        chk("tag_hs", hs, 1);
        chk("tag_wait", waitc, 1);
        tag_valid = 1'b0;
        tag_in = 16'($urandom);
    endtask

    task automatic send_block(input logic [15:0] tag, input int gap_pct, input int stall_pct,
                              input int frz_pct, input bit fast);
        logic [255:0] exp;
        logic [255:0] held = '0;
        int nb;
        int cyc = 0;
        int bi = 0;
        int consumed = 0;
        int first_ov = -1;
        bit ov_seen = 1'b0;
        bit done = 1'b0;
        while (beats.size() < 8) beats.push_back($urandom);
        model_block(tag, exp, nb);
        tag_handshake(tag);
        while (!done && cyc < 300) begin
            wrtEn = ($urandom_range(99) >= frz_pct);
            if (bi < nb) begin
                data_valid = ($urandom_range(99) >= gap_pct);
                data_in = data_valid ? beats[bi] : $urandom;
            end else begin
                data_valid = 1'($urandom_range(1));
                data_in = $urandom;
            end
            out_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            chk("tag_rdy_busy", tag_ready, 0);
            if (!wrtEn) chk("rdy_frozen", data_ready, 0);
            if (out_valid) begin
                if (ov_seen) chk("out_stable", data_out, held);
                else begin ov_seen = 1'b1; held = data_out; first_ov = cyc; end
            end
            if (data_valid && data_ready) begin
                consumed++;
                if (bi < nb) bi++;
            end
            if (out_valid && out_ready && wrtEn) begin
                chk("blk_data", data_out, exp);
                done = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("blk_done", done, 1);
        chk("beats_used", consumed, nb);
        if (fast) chk("latency", first_ov, 8);
        blk_exp++;
        lit_exp += nb;
        wrtEn = 1'b1; data_valid = 1'b0; out_ready = 1'b0;
        beats.delete();
    endtask

    task automatic do_reset_check();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_tag_rdy", tag_ready, 0);
        chk("rst_data_rdy", data_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        @(negedge clk);
        chk("post_rst_tag_rdy", tag_ready, 1);
        @(posedge clk); #1;
        prev_m = 32'h0;
        blk_exp = 0;
        lit_exp = 0;
    endtask

    task automatic reset_mid_block();
        int consumed = 0;
        int cyc = 0;
        tag_handshake(16'hAAAA);
        while (consumed < 3 && cyc < 50) begin
            data_valid = 1'b1; data_in = 32'hFEDCBA98;
            @(negedge clk);
            if (data_valid && data_ready) consumed++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_beats", consumed, 3);
        data_valid = 1'b0;
        do_reset_check();
    endtask

    initial begin
        reset = 1'b1; wrtEn = 1'b1; tag_in = 16'h0; tag_valid = 1'b0;
        data_in = 32'h0; data_valid = 1'b0; out_ready = 1'b0;
        prev_m = 32'h0; blk_exp = 0; lit_exp = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset_check();

        for (int i = 0; i < 8; i++) beats.push_back(32'hFEDCBA98);
        send_block(16'hAAAA, 0, 0, 0, 1'b1);
        send_block(16'h0000, 0, 0, 0, 1'b1);
        beats.push_back(32'h12345678);
        send_block(16'h5556, 0, 0, 0, 1'b1);
        send_block(16'h5555, 0, 0, 0, 1'b1);
        for (int i = 0; i < 8; i++) beats.push_back(32'h00008001);
        send_block(16'hFFFF, 0, 0, 0, 1'b1);
        for (int i = 0; i < 8; i++) beats.push_back(32'hABCD7FFF);
        send_block(16'hFFFF, 0, 0, 0, 1'b1);
        for (int i = 0; i < 8; i++) beats.push_back(32'hFEDCBA98);
        send_block(16'hAAAA, 30, 60, 0, 1'b0);

        reset_mid_block();
        send_block(16'h5555, 0, 0, 0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            if (i % 4 == 0) send_block(16'($urandom), 0, 0, 0, 1'b1);
            else send_block(16'($urandom), $urandom_range(40), $urandom_range(50),
                            $urandom_range(20), 1'b0);
        end

`ifdef DECOMP_STATS_EN
        chk("blk_count", blk_count, blk_exp);
        chk("lit_count", lit_count, lit_exp);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
